// File: rtl/imem_ctrl.sv
// Instruction memory sequencer: arbitrates the single-port memory between the
// boot loader (writes) and the fetch stage (paired reads).
module imem_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic              ld_ready,
  input  logic              reload,
  input  logic              fe_req,
  input  logic [ADDR_W-1:0] fe_addr,
  output logic              fe_gnt,
  output logic              fe_valid,
  output logic [DATA_W-1:0] fe_inst_0,
  output logic [DATA_W-1:0] fe_inst_1,
  output logic              boot_done,
  output logic [ADDR_W:0]   load_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data_1,
  input  logic [DATA_W-1:0] mem_rd_data_2
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1) << ADDR_W;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;

  // State, load counter and pending-read flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // Next state and memory/handshake outputs; everything is forced low during reset
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = 1'b0;
    ld_ready    = 1'b0;
    fe_gnt      = 1'b0;
    boot_done   = 1'b0;
    mem_cen     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    fe_valid    = 1'b0;
    fe_inst_0   = '0;
    fe_inst_1   = '0;
    load_cnt    = '0;

    case (state_q)
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_cen     = 1'b1;
          mem_wen     = 1'b1;
          mem_addr    = ld_addr;
          mem_wr_data = ld_data;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (ld_done) begin
          state_d = RUN;
        end
      end
      RUN: begin
        boot_done = 1'b1;
        if (reload) begin
          // A read still outstanding is re-presented during the single DRAIN cycle
          if (pending_q) begin
            state_d   = DRAIN;
            pending_d = 1'b1;
          end else begin
            state_d = LOAD;
            cnt_d   = '0;
          end
        end else if (fe_req) begin
          fe_gnt    = 1'b1;
          mem_cen   = 1'b1;
          mem_addr  = fe_addr;
          pending_d = 1'b1;
        end
      end
      DRAIN: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase

    if (rst) begin
      ld_ready    = 1'b0;
      fe_gnt      = 1'b0;
      boot_done   = 1'b0;
      mem_cen     = 1'b0;
      mem_wen     = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
    end else begin
      fe_valid  = pending_q;
      fe_inst_0 = mem_rd_data_1;
      fe_inst_1 = mem_rd_data_2;
      load_cnt  = cnt_q;
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: memory model plus a cycle-level reference of the
// load/run/drain protocol, driven by directed and random stimulus.
module tb_imem_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_done;
  logic          ld_ready;
  logic          reload;
  logic          fe_req;
  logic [AW-1:0] fe_addr;
  logic          fe_gnt;
  logic          fe_valid;
  logic [DW-1:0] fe_inst_0;
  logic [DW-1:0] fe_inst_1;
  logic          boot_done;
  logic [AW:0]   load_cnt;
  logic [AW-1:0] mem_addr;
  logic          mem_cen;
  logic          mem_wen;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data_1;
  logic [DW-1:0] mem_rd_data_2;

  imem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_done(ld_done), .ld_ready(ld_ready), .reload(reload),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_gnt(fe_gnt),
    .fe_valid(fe_valid), .fe_inst_0(fe_inst_0), .fe_inst_1(fe_inst_1),
    .boot_done(boot_done), .load_cnt(load_cnt),
    .mem_addr(mem_addr), .mem_cen(mem_cen), .mem_wen(mem_wen),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data_1(mem_rd_data_1), .mem_rd_data_2(mem_rd_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with registered dual read ports, driven only by the DUT
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    mem_rd_data_1 = '0;
    mem_rd_data_2 = '0;
  end
  always @(posedge clk) begin
    if (mem_cen && mem_wen) begin
      mem[mem_addr] <= mem_wr_data;
    end else if (mem_cen) begin
      mem_rd_data_1 <= mem[mem_addr];
      mem_rd_data_2 <= mem[AW'(mem_addr + AW'(1))];
    end
  end

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: what the loader has written, which mode we are in, and the
  // read result (if any) the fetch stage should be seeing this cycle
  typedef enum int {M_LOAD, M_RUN, M_DRAIN} mode_t;
  mode_t         m_mode;
  int            m_cnt;
  logic [DW-1:0] gold [DEPTH];
  logic [DW-1:0] q_inst [$];
  logic [DW-1:0] last0, last1;

  task automatic step(input bit r, input bit lv, input logic [AW-1:0] la,
                      input logic [DW-1:0] ldat, input bit dn, input bit rl,
                      input bit fr, input logic [AW-1:0] fa);
    bit            e_ready, e_gnt, e_valid, e_boot, e_cen, e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    int            e_cnt;
    mode_t         n_mode;
    logic [DW-1:0] d0, d1;
    rst = r; ld_valid = lv; ld_addr = la; ld_data = ldat; ld_done = dn;
    reload = rl; fe_req = fr; fe_addr = fa;
    @(negedge clk);
    e_ready = 0; e_gnt = 0; e_boot = 0; e_cen = 0; e_wen = 0;
    e_addr = '0; e_wd = '0; e_cnt = 0;
    e_valid = 0;
    n_mode = m_mode;
    if (r) begin
      check("inst0_rst", 64'(fe_inst_0), 64'd0);
      check("inst1_rst", 64'(fe_inst_1), 64'd0);
      q_inst.delete();
      m_cnt = 0;
      n_mode = M_LOAD;
    end else begin
      e_cnt = m_cnt;
      e_valid = (q_inst.size() != 0);
      if (e_valid) begin
        d0 = q_inst.pop_front();
        d1 = q_inst.pop_front();
        check("fe_inst_0", 64'(fe_inst_0), 64'(d0));
        check("fe_inst_1", 64'(fe_inst_1), 64'(d1));
        last0 = d0; last1 = d1;
      end
      case (m_mode)
        M_LOAD: begin
          e_ready = 1;
          if (lv) begin
            e_cen = 1; e_wen = 1; e_addr = la; e_wd = ldat;
            gold[la] = ldat;
            m_cnt = (m_cnt + 1 > int'(DEPTH)) ? int'(DEPTH) : m_cnt + 1;
          end
          if (dn) n_mode = M_RUN;
        end
        M_RUN: begin
          e_boot = 1;
          if (rl && e_valid) begin
            // outstanding result is shown once more in the drain cycle
            n_mode = M_DRAIN;
            q_inst.push_back(last0);
            q_inst.push_back(last1);
          end else if (rl) begin
            n_mode = M_LOAD;
            m_cnt = 0;
          end else if (fr) begin
            e_gnt = 1; e_cen = 1; e_addr = fa;
            q_inst.push_back(gold[fa]);
            q_inst.push_back(gold[(int'(fa) + 1) % int'(DEPTH)]);
          end
        end
        default: begin
          n_mode = M_LOAD;
          m_cnt = 0;
        end
      endcase
    end
    check("ld_ready", 64'(ld_ready), 64'(e_ready));
    check("fe_gnt", 64'(fe_gnt), 64'(e_gnt));
    check("fe_valid", 64'(fe_valid), 64'(e_valid));
    check("boot_done", 64'(boot_done), 64'(e_boot));
    check("load_cnt", 64'(load_cnt), 64'(e_cnt));
    check("mem_cen", 64'(mem_cen), 64'(e_cen));
    check("mem_wen", 64'(mem_wen), 64'(e_wen));
    check("mem_addr", 64'(mem_addr), 64'(e_addr));
    check("mem_wr_data", 64'(mem_wr_data), 64'(e_wd));
    m_mode = n_mode;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_mode = M_LOAD;
    m_cnt = 0;
    last0 = '0; last1 = '0;
    for (int i = 0; i < int'(DEPTH); i++) gold[i] = '0;
    rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    reload = 1'b0; fe_req = 1'b0; fe_addr = '0;

    step(1'b1, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'd9, 32'h9, 1'b1, 1'b1, 1'b1, 8'd0);
    // load program, including the wrap word at the top address
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, AW'(i), DW'(32'h11 * (i + 1)), 1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b1, 8'd255, 32'hAA, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'd4, 32'h55, 1'b1, 1'b0, 1'b0, 8'd0);
    // back-to-back fetches, wrap fetch, then reload with a read outstanding
    step(1'b0, 1'b1, 8'd7, 32'h77, 1'b1, 1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, 1'b1, 8'd2);
    step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, 1'b1, 8'd255);
    step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b1, 1'b1, 8'd4);
    step(1'b0, 1'b1, 8'd8, 32'h88, 1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, 1'b0, 8'd0);
    // saturate the write counter
    for (int i = 0; i < int'(DEPTH) + 4; i++)
      step(1'b0, 1'b1, AW'(i), DW'(32'h1000 + i), 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 1'b0, 8'd0);
    // reload with nothing outstanding, then back to run
    step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 1'b0, 8'd0);
    // reset in the cycle after a grant
    step(1'b0, 1'b1, 8'd3, 32'h33, 1'b0, 1'b0, 1'b1, 8'd255);
    step(1'b1, 1'b1, 8'd3, 32'h33, 1'b0, 1'b0, 1'b1, 8'd1);
    step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, 1'b1, 8'd1);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(63) == 0, $urandom_range(1) == 1, AW'($urandom),
           $urandom, $urandom_range(15) == 0, $urandom_range(7) == 0,
           $urandom_range(9) < 7, AW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Sequencing controller for the single-port instruction memory. It owns the memory's `addr`/`cen`/`wen`/`wr_data` pins and shares them between the boot loader, which writes the program, and the fetch stage, which reads two consecutive instruction words per access. A three-state FSM (LOAD, RUN, DRAIN) ensures that only one requester reaches the memory at a time. It also ensures that no read result is lost when the design drops back into load mode.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction memory address width; equals `INST_MEM_DEPTH_BIT`.
- `DATA_W`, default 32: instruction word width; equals `INST_MEM_WIDTH`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ld_valid` in 1: loader has a word to write.
- `ld_addr` in `ADDR_W`: loader write address.
- `ld_data` in `DATA_W`: loader write data.
- `ld_done` in 1: loader finished; level is sampled in LOAD only.
- `ld_ready` out 1: controller accepts a loader write this cycle.
- `reload` in 1: request to return from RUN to LOAD.
- `fe_req` in 1: fetch requests a read.
- `fe_addr` in `ADDR_W`: fetch address.
- `fe_gnt` out 1: fetch read issued this cycle.
- `fe_valid` out 1: `fe_inst_0` and `fe_inst_1` are valid this cycle.
- `fe_inst_0` out `DATA_W`: word at the granted `fe_addr`.
- `fe_inst_1` out `DATA_W`: word at `fe_addr+1`, taken modulo 2^`ADDR_W`.
- `boot_done` out 1: high while in RUN.
- `load_cnt` out `ADDR_W+1`: number of writes accepted since entering LOAD; saturates at 2^`ADDR_W`.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_cen` out 1: memory enable.
- `mem_wen` out 1: memory write enable.
- `mem_wr_data` out `DATA_W`: memory write data.
- `mem_rd_data_1` in `DATA_W`: memory read port 1, registered inside the memory.
- `mem_rd_data_2` in `DATA_W`: memory read port 2, registered inside the memory.

## Operation
**Reset.** While `rst` is high:
- The FSM goes to LOAD on the next edge.
- All outputs are 0, including `ld_ready`.
- `load_cnt` is 0.
- The pending-read flag is cleared.
- This applies in every state. A read in flight at reset is discarded, so `fe_valid` stays 0 after reset.

**Memory-pin defaults.** When nothing is issued: `mem_cen`=0, `mem_wen`=0, `mem_addr`=0, `mem_wr_data`=0.

**LOAD state.**
- `ld_ready`=1 and `fe_gnt`=0.
- A cycle with `ld_valid`=1 is a write: `mem_cen`=1, `mem_wen`=1, `mem_addr`=`ld_addr`, `mem_wr_data`=`ld_data`.
- Each write increments `load_cnt`, saturating at 2^`ADDR_W`.
- `ld_done`=1 moves the FSM to RUN. If `ld_valid` is also high that cycle, the write is still performed.
- `fe_req` is ignored.

**RUN state.**
- `boot_done`=1 and `ld_ready`=0; `ld_valid` and `ld_done` are ignored.
- `fe_gnt` = `fe_req` & !`reload`.
- On a grant: `mem_cen`=1, `mem_wen`=0, `mem_addr`=`fe_addr`, and the pending flag is set for the next cycle.
- Back-to-back grants are allowed, one per cycle.

**Reload from RUN.** `reload`=1 wins over `fe_req`, so no grant is given that cycle.
- If the pending flag is set that cycle, go to DRAIN.
- Otherwise go to LOAD, and clear `load_cnt` on entry.

**DRAIN state.**
- Exactly one cycle; no grants and `ld_ready`=0.
- Delivers the last read result, then goes to LOAD and clears `load_cnt`.

**Read return.**
- `fe_valid` = pending flag, which is registered.
- `fe_inst_0` = `mem_rd_data_1` and `fe_inst_1` = `mem_rd_data_2`; both are passed through combinationally.
- The fetch stage must consume the data in the `fe_valid` cycle; the controller does not hold it.

**Address wrap.** `fe_addr` = 2^`ADDR_W`-1 returns the word at address 0 on `fe_inst_1`. This is handled in the memory; the controller passes the address through unchanged.

## Timing
- Write latency: a write accepted in cycle N is visible to a read issued in cycle N+1 or later.
- Read latency: a grant in cycle N gives `fe_valid`=1 in cycle N+1 with that grant's data. Grants in N and N+1 give `fe_valid` high in N+1 and N+2.
- LOAD to RUN: `ld_done` in cycle N makes `boot_done`=1 and allows `fe_gnt` from cycle N+1.
- RUN to LOAD with a read pending: `reload` in N, DRAIN in N+1 (where `fe_valid`=1), `ld_ready`=1 in N+2.
- RUN to LOAD with no read pending: `reload` in N gives `ld_ready`=1 in N+1.
- `rst` high in cycle N: all outputs are 0 in N, and the controller is in LOAD with `ld_ready`=1 from N+1, provided `rst` has dropped.

## Test plan
- **Reset and load:** release `rst`, then write addr 0..3 = 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Required: `ld_ready`=1, `mem_wen`/`mem_cen`=1 each cycle, `load_cnt`=4, `boot_done`=0.
- **Done with final write:** `ld_valid`=1 and `ld_done`=1 together at addr 4 = 0x55.
  - Required: the write is performed and `boot_done`=1 the next cycle.
- **Back-to-back fetch:** in RUN, `fe_req` with `fe_addr`=0 and then 2 on consecutive cycles.
  - Required: `fe_valid` on the two following cycles with inst pairs (0x11,0x22) then (0x33,0x44).
- **Wrap:** preload addr 255=0xAA and addr 0=0x11, then fetch `fe_addr`=255.
  - Required: `fe_inst_0`=0xAA, `fe_inst_1`=0x11.
- **Reload during a read:**
  - `reload` together with `fe_req`: required `fe_gnt`=0.
  - `reload` one cycle after a grant: required `fe_valid`=1 in the DRAIN cycle, `ld_ready`=1 one cycle later, `load_cnt`=0.
- **Mid-operation reset:** `rst` pulse in the cycle after a grant.
  - Required: `fe_valid`=0, all outputs 0, controller back in LOAD, `ld_valid` in RUN never writes memory.
